// File: rtl/znmi_ctrl.sv
// Z80 NMI request controller: turns one-cycle break/button strobes into a timed /NMI pulse and tracks the handler.
// Optional RETN-based handler exit is enabled by defining ZNMI_RETN_DETECT_EN.
`timescale 1ns/1ps

module znmi_ctrl #(
    parameter int          NMI_LEN     = 32,
    parameter int          ACK_TIMEOUT = 1023,
    parameter logic [15:0] ACK_ADDR    = 16'h0066
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic        zpos,
    input  logic        zneg,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  logic        mreq_n,
    input  logic        m1_n,
    input  logic        rd_n,
    input  logic        req_brk,
    input  logic        req_btn,
    input  logic        nmi_ena,
    input  logic        clr_nmi,
    output logic        nmi_n,
    output logic        in_nmi,
    output logic [1:0]  nmi_src,
    output logic        ack_timeout
);

    localparam int CNT_MAX = (NMI_LEN > ACK_TIMEOUT) ? NMI_LEN : ACK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_ACK,
        S_IN_NMI
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          nmi_n_nx, in_nmi_nx, ack_timeout_nx;
    logic [1:0]    nmi_src_nx;
    logic          ack_hit;
    logic          retn_exit;

    assign ack_hit = zneg && !mreq_n && !m1_n && (a == ACK_ADDR);

`ifdef ZNMI_RETN_DETECT_EN
    logic [7:0] op_cur, op_prev;
    logic       op_valid, m1_q, m1_rise;

    assign m1_rise   = !m1_q && m1_n;
    assign retn_exit = (state == S_IN_NMI) && m1_rise && op_valid &&
                       (op_prev == 8'hED) && (op_cur[7:6] == 2'b01) &&
                       (op_cur[2:0] == 3'b101) && (op_cur != 8'h4D);

    // Opcode history is only meaningful inside the handler, so it is wiped whenever we are outside it.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q     <= 1'b1;
            op_cur   <= 8'h00;
            op_prev  <= 8'h00;
            op_valid <= 1'b0;
        end else begin
            m1_q <= m1_n;
            if (state != S_IN_NMI) begin
                op_prev  <= 8'h00;
                op_valid <= 1'b0;
            end else if (zpos && !m1_n && !mreq_n && !rd_n) begin
                op_cur   <= d;
                op_valid <= 1'b1;
            end else if (m1_rise) begin
                op_prev  <= op_valid ? op_cur : 8'h00;
                op_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_bus;
    assign unused_bus = ^{d, rd_n};
    assign retn_exit  = 1'b0;
`endif

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            nmi_n       <= 1'b1;
            in_nmi      <= 1'b0;
            nmi_src     <= 2'b00;
            ack_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            nmi_n       <= nmi_n_nx;
            in_nmi      <= in_nmi_nx;
            nmi_src     <= nmi_src_nx;
            ack_timeout <= ack_timeout_nx;
        end
    end

    // The acknowledge is checked before the counter so it wins a same-cycle terminal count.
    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        nmi_n_nx       = nmi_n;
        in_nmi_nx      = in_nmi;
        nmi_src_nx     = nmi_src;
        ack_timeout_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (nmi_ena && (req_brk || req_btn)) begin
                    nmi_src_nx = req_brk ? 2'b01 : 2'b10;
                    nmi_n_nx   = 1'b0;
                    cnt_nx     = '0;
                    state_nx   = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (ack_hit) begin
                    nmi_n_nx  = 1'b1;
                    in_nmi_nx = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = S_IN_NMI;
                end else if (zpos) begin
                    if (cnt == CW'(NMI_LEN - 1)) begin
                        cnt_nx   = '0;
                        state_nx = S_WAIT_ACK;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            S_WAIT_ACK: begin
                if (ack_hit) begin
                    nmi_n_nx  = 1'b1;
                    in_nmi_nx = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = S_IN_NMI;
                end else if (zpos) begin
                    if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                        ack_timeout_nx = 1'b1;
                        nmi_n_nx       = 1'b1;
                        cnt_nx         = '0;
                        state_nx       = S_IDLE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            S_IN_NMI: begin
                nmi_n_nx = 1'b1;
                if (clr_nmi || retn_exit) begin
                    in_nmi_nx = 1'b0;
                    state_nx  = S_IDLE;
                end
            end
            default: begin
                state_nx  = S_IDLE;
                nmi_n_nx  = 1'b1;
                in_nmi_nx = 1'b0;
                cnt_nx    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_znmi_ctrl.sv
// Scoreboard bench for znmi_ctrl: expected {nmi_n, in_nmi, nmi_src, ack_timeout} is queued as stimulus is driven.
`timescale 1ns/1ps

module tb_znmi_ctrl;

    logic        fclk = 1'b0, rst_n = 1'b0, zpos = 1'b0, zneg = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d = 8'h00;
    logic        mreq_n = 1'b1, m1_n = 1'b1, rd_n = 1'b1;
    logic        req_brk = 1'b0, req_btn = 1'b0, nmi_ena = 1'b0, clr_nmi = 1'b0;
    logic        nmi_n, in_nmi, ack_timeout;
    logic [1:0]  nmi_src;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] val;
        string      name;
    } exp_t;
    exp_t sb[$];

    always #5 fclk = ~fclk;

    znmi_ctrl dut (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .a(a), .d(d),
        .mreq_n(mreq_n), .m1_n(m1_n), .rd_n(rd_n), .req_brk(req_brk), .req_btn(req_btn),
        .nmi_ena(nmi_ena), .clr_nmi(clr_nmi), .nmi_n(nmi_n), .in_nmi(in_nmi),
        .nmi_src(nmi_src), .ack_timeout(ack_timeout)
    );

    function automatic logic [4:0] observe();
        return {nmi_n, in_nmi, nmi_src, ack_timeout};
    endfunction

    function automatic logic [4:0] pack(input logic n, input logic i, input logic [1:0] s, input logic t);
        return {n, i, s, t};
    endfunction

    task automatic expect_out(input logic [4:0] v, input string nm);
        exp_t e;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge fclk);
    endtask

    task automatic bus_idle();
        a = 16'h0000; m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic z_clocks(input int n);
        for (int k = 0; k < n; k++) begin
            zpos = 1'b1; step(); zpos = 1'b0;
            zneg = 1'b1; step(); zneg = 1'b0;
        end
    endtask

    task automatic ack_fetch();
        a = 16'h0066; m1_n = 1'b0; mreq_n = 1'b0; zneg = 1'b1;
        step();
        zneg = 1'b0;
        bus_idle();
    endtask

    task automatic pulse_brk();  req_brk = 1'b1; step(); req_brk = 1'b0; endtask
    task automatic pulse_btn();  req_btn = 1'b1; step(); req_btn = 1'b0; endtask
    task automatic pulse_clr();  clr_nmi = 1'b1; step(); clr_nmi = 1'b0; endtask

    task automatic test_reset();
        exp_t e;
        for (int ph = 0; ph < 2; ph++) begin
            case (ph)
                0: begin rst_n = 1'b0; expect_out(pack(1, 0, 2'b00, 0), "reset_hold"); step(); step(); end
                default: begin rst_n = 1'b1; expect_out(pack(1, 0, 2'b00, 0), "reset_release"); step(); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_basic_ack();
        exp_t e;
        nmi_ena = 1'b1;
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin expect_out(pack(0, 0, 2'b01, 0), "brk_assert"); pulse_brk(); end
                1: begin expect_out(pack(0, 0, 2'b01, 0), "assert_hold_31"); z_clocks(31); end
                2: begin expect_out(pack(0, 0, 2'b01, 0), "wait_ack_hold"); z_clocks(1); end
                3: begin expect_out(pack(1, 1, 2'b01, 0), "ack_enter"); ack_fetch(); end
                default: begin expect_out(pack(1, 0, 2'b01, 0), "clr_exit"); pulse_clr(); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin
                    req_brk = 1'b1; req_btn = 1'b1;
                    expect_out(pack(0, 0, 2'b01, 0), "both_brk_wins");
                    step(); req_brk = 1'b0; req_btn = 1'b0;
                end
                1: begin expect_out(pack(1, 1, 2'b01, 0), "both_ack"); ack_fetch(); end
                2: begin expect_out(pack(1, 0, 2'b01, 0), "both_clr"); pulse_clr(); end
                3: begin expect_out(pack(0, 0, 2'b10, 0), "btn_src"); pulse_btn(); end
                4: begin expect_out(pack(1, 1, 2'b10, 0), "btn_ack"); ack_fetch(); end
                default: begin expect_out(pack(1, 0, 2'b10, 0), "btn_clr_src_held"); pulse_clr(); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin expect_out(pack(0, 0, 2'b10, 0), "to_assert"); pulse_btn(); end
                1: begin expect_out(pack(0, 0, 2'b10, 0), "to_last_before"); z_clocks(32 + 1022); end
                2: begin
                    expect_out(pack(1, 0, 2'b10, 1), "to_pulse");
                    zpos = 1'b1; step(); zpos = 1'b0;
                end
                default: begin expect_out(pack(1, 0, 2'b10, 0), "to_pulse_end"); step(); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_drop();
        exp_t e;
        for (int ph = 0; ph < 8; ph++) begin
            case (ph)
                0: begin
                    nmi_ena = 1'b0;
                    expect_out(pack(1, 0, 2'b10, 0), "disabled_drop");
                    pulse_brk(); nmi_ena = 1'b1;
                end
                1: begin expect_out(pack(1, 0, 2'b10, 0), "idle_ack_ignored"); ack_fetch(); end
                2: begin expect_out(pack(0, 0, 2'b01, 0), "drop_brk"); pulse_brk(); end
                3: begin expect_out(pack(0, 0, 2'b01, 0), "clr_in_assert_ignored"); pulse_clr(); end
                4: begin expect_out(pack(1, 1, 2'b01, 0), "drop_ack"); ack_fetch(); end
                5: begin expect_out(pack(1, 1, 2'b01, 0), "req_in_nmi_dropped"); pulse_btn(); end
                6: begin
                    nmi_ena = 1'b0;
                    expect_out(pack(1, 1, 2'b01, 0), "ena_low_holds_in_nmi");
                    z_clocks(2);
                end
                default: begin
                    nmi_ena = 1'b1;
                    expect_out(pack(1, 0, 2'b01, 0), "drop_clr");
                    pulse_clr();
                end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_early_ack();
        exp_t e;
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin expect_out(pack(0, 0, 2'b10, 0), "early_assert"); pulse_btn(); end
                1: begin expect_out(pack(1, 1, 2'b10, 0), "early_ack_cnt5"); z_clocks(5); ack_fetch(); end
                2: begin expect_out(pack(1, 0, 2'b10, 0), "early_clr"); pulse_clr(); end
                3: begin expect_out(pack(0, 0, 2'b01, 0), "coinc_assert"); pulse_brk(); z_clocks(31); end
                4: begin
                    a = 16'h0066; m1_n = 1'b0; mreq_n = 1'b0; zpos = 1'b1; zneg = 1'b1;
                    expect_out(pack(1, 1, 2'b01, 0), "ack_beats_terminal");
                    step(); zpos = 1'b0; zneg = 1'b0; bus_idle();
                end
                default: begin expect_out(pack(1, 0, 2'b01, 0), "coinc_clr"); pulse_clr(); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin expect_out(pack(0, 0, 2'b01, 0), "ar_wait_ack"); pulse_brk(); z_clocks(40); end
                1: begin
                    #2 rst_n = 1'b0;
                    #1 expect_out(pack(1, 0, 2'b00, 0), "async_reset_wait_ack");
                end
                2: begin
                    step(); rst_n = 1'b1; step();
                    expect_out(pack(1, 1, 2'b10, 0), "ar_in_nmi");
                    pulse_btn(); ack_fetch();
                end
                3: begin
                    #2 rst_n = 1'b0;
                    #1 expect_out(pack(1, 0, 2'b00, 0), "async_reset_in_nmi");
                end
                default: begin
                    step(); rst_n = 1'b1;
                    expect_out(pack(1, 0, 2'b00, 0), "ar_after_release");
                    step();
                end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin expect_out(pack(1, 1, 2'b01, 0), "b2b_enter"); pulse_brk(); ack_fetch(); end
                1: begin
                    clr_nmi = 1'b1; req_btn = 1'b1;
                    expect_out(pack(1, 0, 2'b01, 0), "b2b_req_with_clr_dropped");
                    step(); clr_nmi = 1'b0; req_btn = 1'b0;
                end
                2: begin expect_out(pack(0, 0, 2'b10, 0), "b2b_next_cycle_req"); pulse_btn(); end
                3: begin expect_out(pack(1, 1, 2'b10, 0), "b2b_ack"); ack_fetch(); end
                default: begin expect_out(pack(1, 0, 2'b10, 0), "b2b_clr"); pulse_clr(); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask

`ifdef ZNMI_RETN_DETECT_EN
    task automatic m1_fetch(input logic [7:0] op);
        a = 16'h1000; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; d = op;
        zneg = 1'b1; step(); zneg = 1'b0;
        zpos = 1'b1; step(); zpos = 1'b0;
        step();
        bus_idle();
        step();
    endtask

    task automatic test_retn();
        exp_t e;
        for (int ph = 0; ph < 9; ph++) begin
            case (ph)
                0: begin expect_out(pack(1, 1, 2'b01, 0), "retn_enter"); pulse_brk(); ack_fetch(); step(); end
                1: begin expect_out(pack(1, 1, 2'b01, 0), "retn_prefix_only"); m1_fetch(8'hED); end
                2: begin expect_out(pack(1, 0, 2'b01, 0), "retn_ed45_exit"); m1_fetch(8'h45); end
                3: begin expect_out(pack(1, 1, 2'b10, 0), "reti_enter"); pulse_btn(); ack_fetch(); step(); end
                4: begin expect_out(pack(1, 1, 2'b10, 0), "reti_ed4d_stays"); m1_fetch(8'hED); m1_fetch(8'h4D); end
                5: begin expect_out(pack(1, 1, 2'b10, 0), "lone_45_stays"); m1_fetch(8'h45); end
                6: begin expect_out(pack(1, 0, 2'b10, 0), "retn_clr_exit"); m1_fetch(8'hED); pulse_clr(); end
                7: begin expect_out(pack(1, 1, 2'b01, 0), "prev_cleared_on_entry"); pulse_brk(); ack_fetch(); step(); m1_fetch(8'h45); end
                default: begin expect_out(pack(1, 0, 2'b01, 0), "retn_ed7d_exit"); m1_fetch(8'hED); m1_fetch(8'h7D); end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front(); checks++;
                if (observe() !== e.val) begin
                    errors++; $display("[TB] FAIL %s: got %b want %b", e.name, observe(), e.val);
                end
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        step();
        test_reset();
        test_basic_ack();
        test_priority();
        test_timeout();
        test_drop();
        test_early_ack();
        test_async_reset();
        nmi_ena = 1'b1;
        test_back_to_back();
`ifdef ZNMI_RETN_DETECT_EN
        test_retn();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/znmi_ctrl.md
Name: znmi_ctrl

Overview:
- Receiving end of the breakpoint and NMI-button requests: takes one-cycle request strobes and drives the Z80 NMI line with defined timing.
- Detects the CPU's acknowledge (M1 fetch at 0x0066) and holds the in_nmi flag for memory-map logic until the handler exits.
- Sits between the request sources (zbreak, keyboard/button logic) and the CPU /NMI pin and mapper.

Parameters:
- NMI_LEN, 32, number of zpos strobes nmi_n is held low before the block waits for the acknowledge.
- ACK_TIMEOUT, 1023, zpos strobes to wait for the acknowledge after NMI_LEN expires; then abort.
- ACK_ADDR, 16'h0066, M1 fetch address that constitutes the acknowledge.

Ports:
- fclk  in  1  global FPGA clock
- rst_n  in  1  asynchronous active-low reset
- zpos  in  1  one-fclk strobe, Z80 clock rising edge
- zneg  in  1  one-fclk strobe, Z80 clock falling edge
- a  in  16  Z80 address bus
- d  in  8  Z80 data bus (used only with the optional feature)
- mreq_n  in  1  Z80 /MREQ
- m1_n  in  1  Z80 /M1
- rd_n  in  1  Z80 /RD
- req_brk  in  1  breakpoint request strobe, one fclk wide
- req_btn  in  1  NMI button request strobe, one fclk wide
- nmi_ena  in  1  global enable; 0 ignores new requests
- clr_nmi  in  1  one-fclk strobe from the port decoder; ends the in_nmi state
- nmi_n  out  1  to CPU /NMI, active low
- in_nmi  out  1  high from the acknowledge until handler exit
- nmi_src  out  2  source of the current or last NMI: 01 = brk, 10 = btn, 00 = none
- ack_timeout  out  1  one-fclk pulse when the acknowledge wait times out

Behaviour:
- Reset: nmi_n=1, in_nmi=0, nmi_src=00, ack_timeout=0, state IDLE, counter=0. Reset mid-operation aborts immediately and releases nmi_n.
- All state changes occur on the fclk rising edge; the counter advances only on cycles with zpos=1.

IDLE:
- Condition: nmi_ena=1 and (req_brk or req_btn).
- Action: set nmi_src (brk wins if both strobes arrive together), drive nmi_n=0, clear the counter, go to ASSERT.
- Requests are not queued: strobes arriving outside IDLE, or while nmi_ena=0, are dropped.

ASSERT:
- nmi_n stays 0.
- Counter counts zpos strobes; when it reaches NMI_LEN-1 with zpos=1: clear the counter, go to WAIT_ACK, keep nmi_n=0.

WAIT_ACK:
- nmi_n stays 0.
- Timeout: when the counter reaches ACK_TIMEOUT-1 with zpos=1, pulse ack_timeout for one fclk, set nmi_n=1, go to IDLE. nmi_src keeps its value.

Acknowledge (ASSERT or WAIT_ACK):
- Condition: zneg and !mreq_n and !m1_n and a==ACK_ADDR.
- Action: next edge nmi_n=1, in_nmi=1, go to IN_NMI.
- If the acknowledge and the counter terminal count coincide, the acknowledge wins.

IN_NMI:
- nmi_n=1, in_nmi=1.
- clr_nmi=1 → in_nmi=0 next edge, go to IDLE.
- clr_nmi outside IN_NMI has no effect.
- nmi_ena falling does not end IN_NMI.

Ack detection:
- A fetch at ACK_ADDR outside ASSERT/WAIT_ACK (e.g. a plain RST-like jump) does not set in_nmi.

nmi_src:
- Updated only on IDLE→ASSERT.
- Held through IN_NMI and afterwards until the next request is accepted.

Optional Feature:
Macro ZNMI_RETN_DETECT_EN.

With the macro defined:
- While in IN_NMI, on each zpos with !m1_n, !mreq_n, !rd_n, latch d as the current opcode byte.
- On the fclk after m1_n rises, evaluate the byte pair.
- Exit condition: previous M1 byte == 8'hED and current byte matches 01xxx101 but is not 8'h4D (RETN variants).
- Exit action: in_nmi=0, go to IDLE, same as clr_nmi.
- The previous-byte register clears on entry to IN_NMI.
- clr_nmi remains functional.

Without the macro:
- d is unused.
- Only clr_nmi ends IN_NMI.

Test Plan:
1. Reset, nmi_ena=1, req_brk pulse → nmi_n=0 next fclk, nmi_src=01; ≥32 zpos later, M1 fetch at 0x0066 on zneg → nmi_n=1, in_nmi=1 next fclk; clr_nmi pulse → in_nmi=0, nmi_n stays 1.
2. req_brk and req_btn in the same fclk → nmi_src=01. Repeat with req_btn alone → nmi_src=10.
3. req_btn, no acknowledge fetch → nmi_n low for 32+1023 zpos strobes, then one ack_timeout pulse, nmi_n=1, in_nmi stays 0.
4. nmi_ena=0 plus a req_brk pulse → nmi_n stays 1. A second req_brk during IN_NMI → dropped, nmi_n stays 1.
5. Acknowledge at zpos count 5 (early, inside ASSERT) → in_nmi=1, nmi_n=1 next fclk. Separately, assert rst_n=0 during WAIT_ACK → nmi_n=1 and in_nmi=0 immediately (asynchronous).
6. (ZNMI_RETN_DETECT_EN) In IN_NMI, M1 fetches ED,45 → in_nmi=0 after m1_n rises. ED,4D (RETI) → in_nmi stays 1. Fetches 45 without a preceding ED → in_nmi stays 1.
